// File: rtl/eth_dma_mem_responder.sv
// eth_dma_mem_responder
//
// AXI4 subordinate for the ethernet DMA master port. It has no IDs and
// supports INCR bursts only. It backs a 2**mem_words_log2-word dual-port RAM
// that holds descriptors and packet buffers in simulation and on-chip
// loopback builds. The write path (AW/W/B) and the read path (AR/R) are
// independent and can run concurrently.
//
// Parameters
//   dma_addr_bits   address width, matches the DMA master
//   dma_word_bits   data width, a power of 2 and >= 32
//   mem_words_log2  RAM depth = 2**mem_words_log2 words
//   base_addr       byte address of word 0 of the window
//
// Ports
//   clock, reset                  sole clock; asynchronous active-high reset
//   s_axi_aw*                     write address: addr, len (beats-1), valid/ready
//   s_axi_w*                      write data: data, strb, last, valid/ready
//   s_axi_b*                      write response: resp (00 OKAY, 10 SLVERR, 11 DECERR), valid/ready
//   s_axi_ar*                     read address: addr, len (beats-1), valid/ready
//   s_axi_r*                      read data: data, resp (00 OKAY, 11 DECERR), last, valid/ready
module eth_dma_mem_responder #(
  parameter int dma_addr_bits  = 64,
  parameter int dma_word_bits  = 64,
  parameter int mem_words_log2 = 12,
  parameter logic [dma_addr_bits-1:0] base_addr = '0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [dma_addr_bits-1:0]   s_axi_awaddr,
  input  logic [7:0]                 s_axi_awlen,
  input  logic                       s_axi_awvalid,
  output logic                       s_axi_awready,
  input  logic [dma_word_bits-1:0]   s_axi_wdata,
  input  logic [dma_word_bits/8-1:0] s_axi_wstrb,
  input  logic                       s_axi_wlast,
  input  logic                       s_axi_wvalid,
  output logic                       s_axi_wready,
  output logic [1:0]                 s_axi_bresp,
  output logic                       s_axi_bvalid,
  input  logic                       s_axi_bready,
  input  logic [dma_addr_bits-1:0]   s_axi_araddr,
  input  logic [7:0]                 s_axi_arlen,
  input  logic                       s_axi_arvalid,
  output logic                       s_axi_arready,
  output logic [dma_word_bits-1:0]   s_axi_rdata,
  output logic [1:0]                 s_axi_rresp,
  output logic                       s_axi_rlast,
  output logic                       s_axi_rvalid,
  input  logic                       s_axi_rready
);

  localparam int strb_bits  = dma_word_bits / 8;
  localparam int byte_shift = $clog2(strb_bits);
  localparam int mem_words  = 2 ** mem_words_log2;

  // Window size in bytes, one bit wider than an address so the top of a
  // full-width window still fits.
  localparam logic [dma_addr_bits:0] win_bytes =
    (dma_addr_bits + 1)'(1) << (mem_words_log2 + byte_shift);

  typedef logic [mem_words_log2-1:0] idx_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_t;

  // Offset from the window base computed one bit wider. An address below
  // base_addr wraps to a value >= 2**dma_addr_bits, which is always larger
  // than the window, so one unsigned compare covers both ends.
  function automatic logic in_window(input logic [dma_addr_bits-1:0] a);
    return (({1'b0, a} - {1'b0, base_addr}) < win_bytes);
  endfunction

  // Word index of a byte address; low byte-lane bits are dropped and the
  // result is truncated to the RAM depth, so bursts wrap at the top.
  function automatic idx_t word_index(input logic [dma_addr_bits-1:0] a);
    return idx_t'((a - base_addr) >> byte_shift);
  endfunction

  logic [dma_word_bits-1:0] mem [mem_words];

  // ---------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------
  w_state_t w_state, w_next;
  idx_t     w_idx;
  logic [7:0] w_len;
  logic [7:0] w_cnt;
  logic     w_hit;
  logic     w_err;
  logic     aw_hs;
  logic     w_hs;
  logic     w_final;

  assign aw_hs   = s_axi_awvalid && s_axi_awready;
  assign w_hs    = s_axi_wvalid && s_axi_wready;
  assign w_final = (w_cnt == w_len);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) w_state <= W_IDLE;
    else       w_state <= w_next;
  end

  // Ready/valid come straight from the state. awready is also held low
  // while reset is asserted so no handshake can be seen during reset.
  always_comb begin
    w_next        = w_state;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    s_axi_bresp   = 2'b00;
    case (w_state)
      W_IDLE: begin
        s_axi_awready = !reset;
        if (s_axi_awvalid && !reset) w_next = W_DATA;
      end
      W_DATA: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid && w_final) w_next = W_RESP;
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        if (!w_hit)     s_axi_bresp = 2'b11;
        else if (w_err) s_axi_bresp = 2'b10;
        else            s_axi_bresp = 2'b00;
        if (s_axi_bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // Burst bookkeeping. The burst ends on the beat count, not on wlast; a
  // wlast that disagrees with the count only makes the error sticky.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      w_idx <= '0;
      w_len <= '0;
      w_cnt <= '0;
      w_hit <= 1'b0;
      w_err <= 1'b0;
    end else if (aw_hs) begin
      w_idx <= word_index(s_axi_awaddr);
      w_len <= s_axi_awlen;
      w_cnt <= '0;
      w_hit <= in_window(s_axi_awaddr);
      w_err <= 1'b0;
    end else if (w_hs) begin
      w_idx <= w_idx + 1'b1;
      w_cnt <= w_cnt + 1'b1;
      if (s_axi_wlast != w_final) w_err <= 1'b1;
    end
  end

  // RAM write port. Beats of a missed burst are accepted but dropped.
  always_ff @(posedge clock) begin
    if (w_hs && w_hit) begin
      for (int b = 0; b < strb_bits; b++) begin
        if (s_axi_wstrb[b]) mem[w_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------
  r_state_t r_state, r_next;
  idx_t     r_idx;
  logic [7:0] r_len;
  logic [7:0] r_cnt;
  logic     r_hit;
  logic     ar_hs;
  logic     r_hs;
  logic     r_final;
  logic     rd_en;
  idx_t     rd_idx;
  logic     rd_hit;
  logic [dma_word_bits-1:0] rdata_q;

  assign ar_hs   = s_axi_arvalid && s_axi_arready;
  assign r_hs    = s_axi_rvalid && s_axi_rready;
  assign r_final = (r_cnt == r_len);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= R_IDLE;
    else       r_state <= r_next;
  end

  always_comb begin
    r_next        = r_state;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    s_axi_rlast   = 1'b0;
    s_axi_rresp   = 2'b00;
    case (r_state)
      R_IDLE: begin
        s_axi_arready = !reset;
        if (s_axi_arvalid && !reset) r_next = R_DATA;
      end
      R_DATA: begin
        s_axi_rvalid = 1'b1;
        s_axi_rlast  = r_final;
        s_axi_rresp  = r_hit ? 2'b00 : 2'b11;
        if (s_axi_rready && r_final) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // The RAM read is issued one cycle ahead of the beat it feeds: on the AR
  // handshake for beat 0, and on each R handshake for the following beat.
  // The data register only loads on those cycles, so a stalled beat holds.
  assign rd_en  = ar_hs || (r_hs && !r_final);
  assign rd_idx = ar_hs ? word_index(s_axi_araddr) : r_idx + 1'b1;
  assign rd_hit = ar_hs ? in_window(s_axi_araddr) : r_hit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_idx   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_hit   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (rd_en) rdata_q <= rd_hit ? mem[rd_idx] : '0;
      if (ar_hs) begin
        r_idx <= rd_idx;
        r_len <= s_axi_arlen;
        r_cnt <= '0;
        r_hit <= rd_hit;
      end else if (r_hs && !r_final) begin
        r_idx <= rd_idx;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign s_axi_rdata = rdata_q;

endmodule

// File: tb/tb_eth_dma_mem_responder.sv
// tb_eth_dma_mem_responder
//
// Self-checking bench for eth_dma_mem_responder. Two instances share all
// inputs: a 4096-word main RAM and a 16-word RAM used for the wrap test.
// Their handshake timing does not depend on the address decode, so both
// stay in lock step and use_small selects whose outputs are observed.
module tb_eth_dma_mem_responder;

  localparam int TMO = 2000;

  logic clock;
  logic reset;
  logic use_small;

  logic [63:0] aw_addr;
  logic [7:0]  aw_len;
  logic        aw_valid;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic        w_last;
  logic        w_valid;
  logic        b_ready;
  logic [63:0] ar_addr;
  logic [7:0]  ar_len;
  logic        ar_valid;
  logic        r_ready;

  logic        mn_awready, mn_wready, mn_bvalid, mn_arready, mn_rlast, mn_rvalid;
  logic [1:0]  mn_bresp, mn_rresp;
  logic [63:0] mn_rdata;
  logic        sm_awready, sm_wready, sm_bvalid, sm_arready, sm_rlast, sm_rvalid;
  logic [1:0]  sm_bresp, sm_rresp;
  logic [63:0] sm_rdata;

  logic        awready, wready, bvalid, arready, rlast, rvalid;
  logic [1:0]  bresp, rresp;
  logic [63:0] rdata;

  int n_vec;
  int n_miss;

  eth_dma_mem_responder #(
    .dma_addr_bits(64), .dma_word_bits(64), .mem_words_log2(12), .base_addr(64'h0)
  ) dut_main (
    .clock(clock), .reset(reset),
    .s_axi_awaddr(aw_addr), .s_axi_awlen(aw_len), .s_axi_awvalid(aw_valid), .s_axi_awready(mn_awready),
    .s_axi_wdata(w_data), .s_axi_wstrb(w_strb), .s_axi_wlast(w_last), .s_axi_wvalid(w_valid),
    .s_axi_wready(mn_wready),
    .s_axi_bresp(mn_bresp), .s_axi_bvalid(mn_bvalid), .s_axi_bready(b_ready),
    .s_axi_araddr(ar_addr), .s_axi_arlen(ar_len), .s_axi_arvalid(ar_valid), .s_axi_arready(mn_arready),
    .s_axi_rdata(mn_rdata), .s_axi_rresp(mn_rresp), .s_axi_rlast(mn_rlast), .s_axi_rvalid(mn_rvalid),
    .s_axi_rready(r_ready)
  );

  eth_dma_mem_responder #(
    .dma_addr_bits(64), .dma_word_bits(64), .mem_words_log2(4), .base_addr(64'h0)
  ) dut_small (
    .clock(clock), .reset(reset),
    .s_axi_awaddr(aw_addr), .s_axi_awlen(aw_len), .s_axi_awvalid(aw_valid), .s_axi_awready(sm_awready),
    .s_axi_wdata(w_data), .s_axi_wstrb(w_strb), .s_axi_wlast(w_last), .s_axi_wvalid(w_valid),
    .s_axi_wready(sm_wready),
    .s_axi_bresp(sm_bresp), .s_axi_bvalid(sm_bvalid), .s_axi_bready(b_ready),
    .s_axi_araddr(ar_addr), .s_axi_arlen(ar_len), .s_axi_arvalid(ar_valid), .s_axi_arready(sm_arready),
    .s_axi_rdata(sm_rdata), .s_axi_rresp(sm_rresp), .s_axi_rlast(sm_rlast), .s_axi_rvalid(sm_rvalid),
    .s_axi_rready(r_ready)
  );

  assign awready = use_small ? sm_awready : mn_awready;
  assign wready  = use_small ? sm_wready  : mn_wready;
  assign bvalid  = use_small ? sm_bvalid  : mn_bvalid;
  assign bresp   = use_small ? sm_bresp   : mn_bresp;
  assign arready = use_small ? sm_arready : mn_arready;
  assign rvalid  = use_small ? sm_rvalid  : mn_rvalid;
  assign rdata   = use_small ? sm_rdata   : mn_rdata;
  assign rresp   = use_small ? sm_rresp   : mn_rresp;
  assign rlast   = use_small ? sm_rlast   : mn_rlast;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit          is_write;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [63:0] data;
    logic [63:0] step;
    logic [7:0]  strb;
    int          last_at;
    logic [1:0]  resp;
    string       name;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_miss++;
    $display("[TB] FAIL %s: no handshake within %0d cycles, expected one", name, TMO);
  endtask

  // Write burst: beat k carries base + k*step; wlast is raised on beat
  // last_at (len for a well-formed burst). Entered and left on a negedge.
  task automatic do_write(input string name, input logic [63:0] addr, input logic [7:0] len,
                          input logic [63:0] base, input logic [63:0] step, input logic [7:0] strb,
                          input int last_at, input logic [1:0] exp_resp);
    int n;
    aw_addr = addr; aw_len = len; aw_valid = 1'b1;
    n = 0;
    while (!awready && n < TMO) begin @(negedge clock); n++; end
    if (n >= TMO) timeout({name, " aw"});
    @(negedge clock);
    aw_valid = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      w_data = base + 64'(k) * step; w_strb = strb; w_last = (k == last_at); w_valid = 1'b1;
      n = 0;
      while (!wready && n < TMO) begin @(negedge clock); n++; end
      if (n >= TMO) timeout({name, " w"});
      @(negedge clock);
    end
    w_valid = 1'b0; w_last = 1'b0;
    b_ready = 1'b1;
    n = 0;
    while (!bvalid && n < TMO) begin @(negedge clock); n++; end
    if (n >= TMO) timeout({name, " b"});
    else check({name, " bresp"}, 128'(bresp), 128'(exp_resp));
    @(negedge clock);
    b_ready = 1'b0;
  endtask

  // Read burst: checks {rdata, rresp, rlast} on every accepted beat.
  // With toggle set, rready alternates starting low so beats are stalled.
  task automatic do_read(input string name, input logic [63:0] addr, input logic [7:0] len,
                         input logic [63:0] base, input logic [63:0] step, input logic [1:0] exp_resp,
                         input bit toggle);
    int n;
    int k;
    bit phase;
    ar_addr = addr; ar_len = len; ar_valid = 1'b1;
    n = 0;
    while (!arready && n < TMO) begin @(negedge clock); n++; end
    if (n >= TMO) timeout({name, " ar"});
    @(negedge clock);
    ar_valid = 1'b0;
    k = 0; n = 0; phase = 1'b0;
    while (k <= int'(len) && n < TMO) begin
      r_ready = toggle ? phase : 1'b1;
      phase = !phase;
      if (rvalid && r_ready) begin
        check($sformatf("%s beat %0d", name, k), 128'({rdata, rresp, rlast}),
              128'({base + 64'(k) * step, exp_resp, (k == int'(len))}));
        k++;
      end
      @(negedge clock);
      n++;
    end
    r_ready = 1'b0;
    if (k <= int'(len)) timeout({name, " r"});
  endtask

  task automatic applyStimulus();
    vecs[0]  = '{1'b1, 64'h0,    8'd0, 64'h1122334455667788, 64'h0, 8'hFF, 0,   2'b00, "single wr"};
    vecs[1]  = '{1'b0, 64'h0,    8'd0, 64'h1122334455667788, 64'h0, 8'hFF, 0,   2'b00, "single rd"};
    vecs[2]  = '{1'b1, 64'h8,    8'd0, 64'hFFFFFFFFFFFFFFFF, 64'h0, 8'hFF, 0,   2'b00, "merge ones"};
    vecs[3]  = '{1'b1, 64'h8,    8'd0, 64'h0,                64'h0, 8'h0F, 0,   2'b00, "merge low"};
    vecs[4]  = '{1'b0, 64'h8,    8'd0, 64'hFFFFFFFF00000000, 64'h0, 8'hFF, 0,   2'b00, "merge rd"};
    vecs[5]  = '{1'b1, 64'h8008, 8'd1, 64'hDEADBEEF00000000, 64'h1, 8'hFF, 1,   2'b11, "decerr wr"};
    vecs[6]  = '{1'b0, 64'h8,    8'd0, 64'hFFFFFFFF00000000, 64'h0, 8'hFF, 0,   2'b00, "decerr keep"};
    vecs[7]  = '{1'b0, 64'h8008, 8'd3, 64'h0,                64'h0, 8'hFF, 0,   2'b11, "decerr rd"};
    vecs[8]  = '{1'b1, 64'h20,   8'd1, 64'h55,               64'h1, 8'hFF, 0,   2'b10, "early wlast"};
    vecs[9]  = '{1'b1, 64'h30,   8'd0, 64'h77,               64'h0, 8'hFF, 255, 2'b10, "late wlast"};
    vecs[10] = '{1'b0, 64'h20,   8'd1, 64'h55,               64'h1, 8'hFF, 0,   2'b00, "early rd"};
    vecs[11] = '{1'b0, 64'h30,   8'd0, 64'h77,               64'h0, 8'hFF, 0,   2'b00, "late rd"};
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].is_write)
        do_write(vecs[i].name, vecs[i].addr, vecs[i].len, vecs[i].data, vecs[i].step,
                 vecs[i].strb, vecs[i].last_at, vecs[i].resp);
      else
        do_read(vecs[i].name, vecs[i].addr, vecs[i].len, vecs[i].data, vecs[i].step,
                vecs[i].resp, 1'b0);
    end
  endtask

  task automatic checkOutput();
    int n;
    // 256-beat burst, read back with rready toggling every cycle.
    do_write("burst256 wr", 64'h100, 8'd255, 64'h0, 64'h1, 8'hFF, 255, 2'b00);
    do_read("burst256 rd", 64'h100, 8'd255, 64'h0, 64'h1, 2'b00, 1'b1);

    // Wrap in the 16-word RAM: words 14, 15, 0, 1.
    use_small = 1'b1;
    do_write("wrap wr", 64'h70, 8'd3, 64'h100, 64'h1, 8'hFF, 3, 2'b00);
    do_read("wrap rd", 64'h70, 8'd3, 64'h100, 64'h1, 2'b00, 1'b0);
    do_read("wrap low", 64'h0, 8'd1, 64'h102, 64'h1, 2'b00, 1'b0);
    use_small = 1'b0;

    // Concurrent write and read on disjoint regions.
    fork
      do_write("conc wr", 64'h1000, 8'd7, 64'h7000, 64'h1, 8'hFF, 7, 2'b00);
      do_read("conc rd", 64'h100, 8'd7, 64'h0, 64'h1, 2'b00, 1'b0);
    join
    do_read("conc chk", 64'h1000, 8'd7, 64'h7000, 64'h1, 2'b00, 1'b0);

    // Reset while beat 3 of an 8-beat write is on the bus.
    aw_addr = 64'h2000; aw_len = 8'd7; aw_valid = 1'b1;
    n = 0;
    while (!awready && n < TMO) begin @(negedge clock); n++; end
    if (n >= TMO) timeout("rst aw");
    @(negedge clock);
    aw_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      w_data = 64'h9000 + 64'(k); w_strb = 8'hFF; w_last = 1'b0; w_valid = 1'b1;
      n = 0;
      while (!wready && n < TMO) begin @(negedge clock); n++; end
      if (n >= TMO) timeout("rst w");
      @(negedge clock);
    end
    w_data = 64'h9003; w_valid = 1'b1;
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    w_valid = 1'b0;
    @(negedge clock);
    check("rst release {bvalid,wready,awready}", 128'({bvalid, wready, awready}), 128'(3'b001));
    do_read("rst kept", 64'h2000, 8'd2, 64'h9000, 64'h1, 2'b00, 1'b0);
    do_write("post rst wr", 64'h3000, 8'd0, 64'hC0FFEE, 64'h0, 8'hFF, 0, 2'b00);
    do_read("post rst rd", 64'h3000, 8'd0, 64'hC0FFEE, 64'h0, 2'b00, 1'b0);
  endtask

  initial begin
    n_vec = 0; n_miss = 0;
    use_small = 1'b0;
    reset = 1'b1;
    aw_addr = '0; aw_len = '0; aw_valid = 1'b0;
    w_data = '0; w_strb = '0; w_last = 1'b0; w_valid = 1'b0; b_ready = 1'b0;
    ar_addr = '0; ar_len = '0; ar_valid = 1'b0; r_ready = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("reset outputs", 128'({awready, wready, bvalid, bresp, arready, rvalid, rresp, rlast, rdata}),
          128'(0));
    reset = 1'b0;
    @(negedge clock);
    check("idle ready {awready,arready}", 128'({awready, arready}), 128'(2'b11));

    applyStimulus();
    checkOutput();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
